// File: rtl/pcpi_check_pkg.sv
// Shared constants and bundle layout for the PCPI lockstep checker.
// Field indices double as bit positions in the failure mask.
package pcpi_check_pkg;

    localparam int F_READY = 3;
    localparam int F_WAIT  = 2;
    localparam int F_RD    = 1;
    localparam int F_WR    = 0;

    localparam int MODE_STRICT = 0;
    localparam int MODE_TXN    = 1;

    localparam int PCPI_XLEN = 32;

    // Default-width view of the golden bundle; the top packs the same
    // {ready, wait, rd, wr} order into an XLEN+3 vector.
    typedef struct packed {
        logic                 ready;
        logic                 busy;
        logic [PCPI_XLEN-1:0] rd;
        logic                 wr;
    } pcpi_bundle_t;

endpackage

// File: rtl/pcpi_skew_line.sv
// SKEW-deep delay line for the golden bundle plus a valid bit.
// SKEW=0 is a straight wire; flush empties the line synchronously.
module pcpi_skew_line #(
    parameter int W    = 35,
    parameter int SKEW = 0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic [W-1:0] out_data,
    output logic         out_valid
);

    generate
        if (SKEW == 0) begin : g_direct
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, resetn, flush};
            assign out_data    = in_data;
            assign out_valid   = in_valid;
        end else begin : g_delay
            logic [W-1:0]    data_q [SKEW];
            logic [SKEW-1:0] valid_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < SKEW; i++) data_q[i] <= '0;
                    valid_q <= '0;
                end else if (flush) begin
                    for (int i = 0; i < SKEW; i++) data_q[i] <= '0;
                    valid_q <= '0;
                end else begin
                    data_q[0]  <= in_data;
                    valid_q[0] <= in_valid;
                    for (int i = 1; i < SKEW; i++) begin
                        data_q[i]  <= data_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign out_data  = data_q[SKEW-1];
            assign out_valid = valid_q[SKEW-1];
        end
    endgenerate

endmodule

// File: rtl/pcpi_lockstep_checker.sv
// Lockstep checker: forwards golden PCPI outputs unchanged and compares a
// skew-aligned golden stream against the DUT, recording the first failure.
module pcpi_lockstep_checker
    import pcpi_check_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SKEW  = 0,
    parameter int MODE  = 1,
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ref_pcpi_ready,
    input  logic             ref_pcpi_wait,
    input  logic             ref_pcpi_wr,
    input  logic [XLEN-1:0]  ref_pcpi_rd,
    input  logic             dut_pcpi_ready,
    input  logic             dut_pcpi_wait,
    input  logic             dut_pcpi_wr,
    input  logic [XLEN-1:0]  dut_pcpi_rd,
    input  logic             clr_err,
    output logic             pcpi_ready,
    output logic             pcpi_wait,
    output logic             pcpi_wr,
    output logic [XLEN-1:0]  pcpi_rd,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CYC_W-1:0] first_cycle,
    output logic [3:0]       first_mask,
    output logic [XLEN-1:0]  first_rd_ref,
    output logic [XLEN-1:0]  first_rd_dut
);

    assign pcpi_ready = ref_pcpi_ready;
    assign pcpi_wait  = ref_pcpi_wait;
    assign pcpi_wr    = ref_pcpi_wr;
    assign pcpi_rd    = ref_pcpi_rd;

    logic [XLEN+2:0] ref_bundle;
    logic [XLEN+2:0] dly_bundle;
    logic            dly_valid;

    assign ref_bundle = {ref_pcpi_ready, ref_pcpi_wait, ref_pcpi_rd, ref_pcpi_wr};

    pcpi_skew_line #(
        .W    (XLEN + 3),
        .SKEW (SKEW)
    ) u_skew (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (clr_err),
        .in_data   (ref_bundle),
        .in_valid  (1'b1),
        .out_data  (dly_bundle),
        .out_valid (dly_valid)
    );

    logic            d_ready;
    logic            d_wait;
    logic            d_wr;
    logic [XLEN-1:0] d_rd;

    assign d_ready = dly_bundle[XLEN+2];
    assign d_wait  = dly_bundle[XLEN+1];
    assign d_rd    = dly_bundle[XLEN:1];
    assign d_wr    = dly_bundle[0];

    logic [3:0] fail_mask;
    logic       fail;

    // Transactional mode only trusts wr/rd while golden says the result is ready.
    always_comb begin
        fail_mask = '0;
        if (dly_valid) begin
            if (MODE == MODE_STRICT) begin
                fail_mask[F_READY] = d_ready != dut_pcpi_ready;
                fail_mask[F_WAIT]  = d_wait  != dut_pcpi_wait;
                fail_mask[F_RD]    = d_rd    != dut_pcpi_rd;
                fail_mask[F_WR]    = d_wr    != dut_pcpi_wr;
            end else begin
                fail_mask[F_READY] = d_ready != dut_pcpi_ready;
                if (d_ready)
                    fail_mask[F_WR] = d_wr != dut_pcpi_wr;
                if (d_ready && d_wr)
                    fail_mask[F_RD] = d_rd != dut_pcpi_rd;
            end
        end
    end

    assign fail = |fail_mask;

    logic [CYC_W-1:0] cyc_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt      <= '0;
            mismatch     <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
            first_cycle  <= '0;
            first_mask   <= '0;
            first_rd_ref <= '0;
            first_rd_dut <= '0;
        end else if (clr_err) begin
            cyc_cnt      <= '0;
            mismatch     <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
            first_cycle  <= '0;
            first_mask   <= '0;
            first_rd_ref <= '0;
            first_rd_dut <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + 1'b1;
            mismatch <= fail;
            if (fail) begin
                err_sticky <= 1'b1;
                if (err_count != {CNT_W{1'b1}})
                    err_count <= err_count + 1'b1;
                if (!err_sticky) begin
                    first_cycle  <= cyc_cnt;
                    first_mask   <= fail_mask;
                    first_rd_ref <= d_rd;
                    first_rd_dut <= dut_pcpi_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcpi_lockstep_checker.sv
// Directed bench: four checker instances (skew 0/2/3, strict and transactional)
// driven from one golden stream with hand-computed expectations.
module tb_pcpi_lockstep_checker;

    logic clk, resetn;
    logic ref_ready, ref_wait, ref_wr;
    logic [31:0] ref_rd;
    logic ac_ready, ac_wait, ac_wr;
    logic [31:0] ac_rd;
    logic bi_ready, bi_wait, bi_wr;
    logic [31:0] bi_rd;
    logic di_ready, di_wait, di_wr;
    logic [31:0] di_rd;
    logic clr_a, clr_b, clr_c, clr_d;

    logic a_ready, a_wait, a_wr, a_mis, a_sticky;
    logic [31:0] a_rd, a_fcyc, a_fref, a_fdut;
    logic [3:0] a_count, a_fmask;
    logic b_ready, b_wait, b_wr, b_mis, b_sticky;
    logic [31:0] b_rd, b_fcyc, b_fref, b_fdut;
    logic [15:0] b_count;
    logic [3:0] b_fmask;
    logic c_ready, c_wait, c_wr, c_mis, c_sticky;
    logic [31:0] c_rd, c_fcyc, c_fref, c_fdut;
    logic [15:0] c_count;
    logic [3:0] c_fmask;
    logic d_ready, d_wait, d_wr, d_mis, d_sticky;
    logic [31:0] d_rd, d_fcyc, d_fref, d_fdut;
    logic [15:0] d_count;
    logic [3:0] d_fmask;

    pcpi_lockstep_checker #(.SKEW(0), .MODE(1), .CNT_W(4)) u_a (
        .clk(clk), .resetn(resetn),
        .ref_pcpi_ready(ref_ready), .ref_pcpi_wait(ref_wait), .ref_pcpi_wr(ref_wr), .ref_pcpi_rd(ref_rd),
        .dut_pcpi_ready(ac_ready), .dut_pcpi_wait(ac_wait), .dut_pcpi_wr(ac_wr), .dut_pcpi_rd(ac_rd),
        .clr_err(clr_a),
        .pcpi_ready(a_ready), .pcpi_wait(a_wait), .pcpi_wr(a_wr), .pcpi_rd(a_rd),
        .mismatch(a_mis), .err_sticky(a_sticky), .err_count(a_count), .first_cycle(a_fcyc),
        .first_mask(a_fmask), .first_rd_ref(a_fref), .first_rd_dut(a_fdut));

    pcpi_lockstep_checker #(.SKEW(2), .MODE(1)) u_b (
        .clk(clk), .resetn(resetn),
        .ref_pcpi_ready(ref_ready), .ref_pcpi_wait(ref_wait), .ref_pcpi_wr(ref_wr), .ref_pcpi_rd(ref_rd),
        .dut_pcpi_ready(bi_ready), .dut_pcpi_wait(bi_wait), .dut_pcpi_wr(bi_wr), .dut_pcpi_rd(bi_rd),
        .clr_err(clr_b),
        .pcpi_ready(b_ready), .pcpi_wait(b_wait), .pcpi_wr(b_wr), .pcpi_rd(b_rd),
        .mismatch(b_mis), .err_sticky(b_sticky), .err_count(b_count), .first_cycle(b_fcyc),
        .first_mask(b_fmask), .first_rd_ref(b_fref), .first_rd_dut(b_fdut));

    pcpi_lockstep_checker #(.SKEW(0), .MODE(0)) u_c (
        .clk(clk), .resetn(resetn),
        .ref_pcpi_ready(ref_ready), .ref_pcpi_wait(ref_wait), .ref_pcpi_wr(ref_wr), .ref_pcpi_rd(ref_rd),
        .dut_pcpi_ready(ac_ready), .dut_pcpi_wait(ac_wait), .dut_pcpi_wr(ac_wr), .dut_pcpi_rd(ac_rd),
        .clr_err(clr_c),
        .pcpi_ready(c_ready), .pcpi_wait(c_wait), .pcpi_wr(c_wr), .pcpi_rd(c_rd),
        .mismatch(c_mis), .err_sticky(c_sticky), .err_count(c_count), .first_cycle(c_fcyc),
        .first_mask(c_fmask), .first_rd_ref(c_fref), .first_rd_dut(c_fdut));

    pcpi_lockstep_checker #(.SKEW(3), .MODE(1)) u_d (
        .clk(clk), .resetn(resetn),
        .ref_pcpi_ready(ref_ready), .ref_pcpi_wait(ref_wait), .ref_pcpi_wr(ref_wr), .ref_pcpi_rd(ref_rd),
        .dut_pcpi_ready(di_ready), .dut_pcpi_wait(di_wait), .dut_pcpi_wr(di_wr), .dut_pcpi_rd(di_rd),
        .clr_err(clr_d),
        .pcpi_ready(d_ready), .pcpi_wait(d_wait), .pcpi_wr(d_wr), .pcpi_rd(d_rd),
        .mismatch(d_mis), .err_sticky(d_sticky), .err_count(d_count), .first_cycle(d_fcyc),
        .first_mask(d_fmask), .first_rd_ref(d_fref), .first_rd_dut(d_fdut));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [34:0] h1 = '0, h2 = '0, h3 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // History records the golden bundle applied during the cycle that just ended.
    task automatic step();
        @(posedge clk);
        #1;
        h3 = h2;
        h2 = h1;
        h1 = {ref_ready, ref_wait, ref_rd, ref_wr};
        cyc++;
    endtask

    task automatic set_gold(input logic r, input logic w, input logic [31:0] rd, input logic wr);
        ref_ready = r; ref_wait = w; ref_rd = rd; ref_wr = wr;
        ac_ready = r; ac_wait = w; ac_rd = rd; ac_wr = wr;
        {bi_ready, bi_wait, bi_rd, bi_wr} = h2;
        {di_ready, di_wait, di_rd, di_wr} = h3;
    endtask

    typedef struct {
        logic        r_ready, r_wait;
        logic [31:0] r_rd;
        logic        r_wr;
        logic        d_ready, d_wait;
        logic [31:0] d_rd;
        logic        d_wr;
        logic        exp_txn, exp_strict;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int v_a_cyc, v_c_cyc;
        logic [31:0] prod;

        vecs[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0, 32'h22, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h6,  1'b1, 1'b1, 1'b0, 32'h6,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h6,  1'b1, 1'b1, 1'b0, 32'h7,  1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h9,  1'b0, 1'b1, 1'b0, 32'h3,  1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h6,  1'b1, 1'b1, 1'b0, 32'h6,  1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};

        resetn = 1'b0;
        clr_a = 0; clr_b = 0; clr_c = 0; clr_d = 0;
        set_gold(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) step();
        chk("reset_a_mis", a_mis, 0);
        chk("reset_a_sticky", a_sticky, 0);
        chk("reset_a_count", a_count, 0);
        chk("reset_b_fcyc", b_fcyc, 0);
        chk("reset_c_fmask", c_fmask, 0);
        chk("reset_d_fref", d_fref, 0);
        resetn = 1'b1;
        cyc = 0;

        // Identical (or skew-aligned) streams: 100 multiply transactions.
        for (int i = 0; i < 100; i++) begin
            set_gold(1'b0, 1'b1, 32'h0, 1'b0);
            #1 chk("pass_wait", {a_ready, a_wait, a_wr}, 3'b010);
            step();
            prod = 32'(i + 3) * 32'(i * 7 + 1);
            set_gold(1'b1, 1'b0, prod, 1'b1);
            #1 chk("pass_rd", a_rd, prod);
            chk("pass_ctl", {a_ready, a_wait, a_wr}, 3'b101);
            step();
        end
        chk("clean_a_sticky", a_sticky, 0);
        chk("clean_a_count", a_count, 0);
        chk("clean_b_sticky", b_sticky, 0);
        chk("clean_c_count", c_count, 0);
        chk("clean_d_sticky", d_sticky, 0);

        // Field-qualification table for transactional (a) and strict (c).
        v_a_cyc = 0; v_c_cyc = 0;
        for (int i = 0; i < 9; i++) begin
            set_gold(vecs[i].r_ready, vecs[i].r_wait, vecs[i].r_rd, vecs[i].r_wr);
            ac_ready = vecs[i].d_ready; ac_wait = vecs[i].d_wait;
            ac_rd = vecs[i].d_rd; ac_wr = vecs[i].d_wr;
            if (i == 4) v_a_cyc = cyc;
            if (i == 1) v_c_cyc = cyc;
            #1 chk("tbl_pass_rd", c_rd, vecs[i].r_rd);
            step();
            chk($sformatf("tbl_txn_mis[%0d]", i), a_mis, vecs[i].exp_txn);
            chk($sformatf("tbl_strict_mis[%0d]", i), c_mis, vecs[i].exp_strict);
        end
        set_gold(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tbl_a_count", a_count, 3);
        chk("tbl_c_count", c_count, 7);
        chk("tbl_a_fcyc", a_fcyc, 64'(v_a_cyc));
        chk("tbl_a_fmask", a_fmask, 4'b0010);
        chk("tbl_a_fref", a_fref, 6);
        chk("tbl_a_fdut", a_fdut, 7);
        chk("tbl_c_fcyc", c_fcyc, 64'(v_c_cyc));
        chk("tbl_c_fmask", c_fmask, 4'b0100);
        chk("tbl_b_sticky", b_sticky, 0);

        // SKEW=2: rd corruption on the DUT side at counter 40.
        for (int k = -1; k <= 44; k++) begin
            if (k >= 0 && (k % 4) == 2) set_gold(1'b1, 1'b0, 32'h6, 1'b1);
            else set_gold(1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 40) bi_rd = 32'h7;
            clr_b = (k == -1);
            step();
            clr_b = 1'b0;
            if (k == 39) chk("skew_no_mis_39", b_mis, 0);
            if (k == 40) begin
                chk("skew_mis", b_mis, 1);
                chk("skew_fcyc", b_fcyc, 40);
                chk("skew_fmask", b_fmask, 4'b0010);
                chk("skew_fref", b_fref, 6);
                chk("skew_fdut", b_fdut, 7);
                chk("skew_count", b_count, 1);
            end
        end
        chk("skew_count_after", b_count, 1);
        chk("skew_d_sticky", d_sticky, 0);

        // SKEW=3: clear beats a same-cycle failure, then 3 guarded cycles.
        set_gold(1'b0, 1'b0, 32'h0, 1'b0);
        di_ready = ~di_ready;
        step();
        chk("clr_d_pre_sticky", d_sticky, 1);
        set_gold(1'b0, 1'b0, 32'h0, 1'b0);
        di_ready = ~di_ready;
        clr_d = 1'b1;
        step();
        clr_d = 1'b0;
        chk("clr_d_mis", d_mis, 0);
        chk("clr_d_sticky", d_sticky, 0);
        chk("clr_d_count", d_count, 0);
        chk("clr_d_fmask", d_fmask, 0);
        chk("clr_d_fcyc", d_fcyc, 0);
        for (int j = 1; j <= 4; j++) begin
            set_gold(1'b0, 1'b0, 32'h0, 1'b0);
            di_ready = ~di_ready;
            step();
            chk($sformatf("guard_mis[%0d]", j), d_mis, (j == 4));
        end
        chk("guard_fcyc", d_fcyc, 3);
        chk("guard_fmask", d_fmask, 4'b1000);
        chk("guard_count", d_count, 1);

        // CNT_W=4 saturation on a.
        set_gold(1'b0, 1'b0, 32'h5, 1'b0);
        ac_ready = 1'b1;
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("sat_clr_count", a_count, 0);
        for (int j = 1; j <= 20; j++) begin
            set_gold(1'b0, 1'b0, 32'h5, 1'b0);
            ac_ready = 1'b1;
            step();
            if (j == 15) chk("sat_count_15", a_count, 15);
        end
        chk("sat_count_20", a_count, 15);
        chk("sat_mis", a_mis, 1);
        chk("sat_sticky", a_sticky, 1);
        chk("sat_fcyc", a_fcyc, 0);
        chk("sat_fmask", a_fmask, 4'b1000);
        chk("sat_fref", a_fref, 5);
        chk("sat_fdut", a_fdut, 5);

        // Asynchronous reset mid-transaction.
        set_gold(1'b0, 1'b1, 32'h0, 1'b0);
        ac_ready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("areset_a_sticky", a_sticky, 0);
        chk("areset_a_count", a_count, 0);
        chk("areset_a_mis", a_mis, 0);
        chk("areset_a_fmask", a_fmask, 0);
        chk("areset_b_fcyc", b_fcyc, 0);
        set_gold(1'b1, 1'b0, 32'hCAFE_F00D, 1'b1);
        #1;
        chk("areset_pass_rd", a_rd, 32'hCAFE_F00D);
        chk("areset_pass_ctl", {a_ready, a_wait, a_wr}, 3'b101);
        step();
        resetn = 1'b1;
        for (int j = 0; j < 5; j++) begin
            set_gold(1'b0, 1'b0, 32'h0, 1'b0);
            step();
        end
        chk("post_reset_a_sticky", a_sticky, 0);
        chk("post_reset_d_sticky", d_sticky, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
